// File: rtl/adsr_env.sv
// adsr_env -- ADSR envelope generator.
//
// Produces a signed fixed-point exponent in the range [-1.0, 0.0] that feeds
// the eexp stage directly. -1.0 is the floor (silence) and 0.0 is the peak.
// The envelope moves only on sample_tick cycles. Each stage adds or subtracts
// a per-tick step and saturates at that stage's bound.
//
// Ports:
//   clk           single clock; all state changes on the rising edge
//   reset_n       asynchronous active-low reset
//   sample_tick   one-cycle strobe, once per audio sample
//   gate          note-on level, sampled only on tick cycles
//   attack_step   per-tick rise toward the peak   (<= 0 : instant)
//   decay_step    per-tick fall toward sustain    (<= 0 : instant)
//   release_step  per-tick fall toward the floor  (<= 0 : instant)
//   sustain_level sustain target, used clamped to [-1.0, 0.0]
//   out           registered envelope level
//   out_valid     one-cycle strobe marking an out update
//   stage         current stage: IDLE=0 ATTACK=1 DECAY=2 SUSTAIN=3 RELEASE=4
//
// out_valid is a plain strobe with no ready/backpressure. It is high for
// exactly the cycle after each tick, which is the cycle in which out first
// shows the value computed on that tick. The consumer must take it then.
module adsr_env #(
  parameter int TOTAL_BITS      = 32,
  parameter int FRACTIONAL_BITS = 16
) (
  input  logic                         clk,
  input  logic                         reset_n,
  input  logic                         sample_tick,
  input  logic                         gate,
  input  logic signed [TOTAL_BITS-1:0] attack_step,
  input  logic signed [TOTAL_BITS-1:0] decay_step,
  input  logic signed [TOTAL_BITS-1:0] release_step,
  input  logic signed [TOTAL_BITS-1:0] sustain_level,
  output logic signed [TOTAL_BITS-1:0] out,
  output logic                         out_valid,
  output logic [2:0]                   stage
);

  localparam int W = TOTAL_BITS;
  localparam logic signed [W-1:0] ONE   = W'(1) << FRACTIONAL_BITS;
  localparam logic signed [W-1:0] FLOOR = -ONE;
  localparam logic signed [W-1:0] PEAK  = '0;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    ATTACK  = 3'd1,
    DECAY   = 3'd2,
    SUSTAIN = 3'd3,
    RELEASE = 3'd4
  } stage_t;

  stage_t              state_q, state_d;
  logic signed [W-1:0] out_q, out_d;
  logic                prev_gate_q, prev_gate_d;
  logic                valid_q;

  // Sustain target limited to the legal output range.
  logic signed [W-1:0] sus_c;
  always_comb begin
    sus_c = sustain_level;
    if (sustain_level < FLOOR) sus_c = FLOOR;
    else if (sustain_level > PEAK) sus_c = PEAK;
  end

  // Arithmetic runs one bit wider than the ports so that a large step
  // cannot wrap before the saturation compare.
  logic signed [W:0] out_w, sus_w, floor_w;
  logic signed [W:0] atk_sum, dec_diff, rel_diff;
  assign out_w    = {out_q[W-1], out_q};
  assign sus_w    = {sus_c[W-1], sus_c};
  assign floor_w  = {FLOOR[W-1], FLOOR};
  assign atk_sum  = out_w + {attack_step[W-1], attack_step};
  assign dec_diff = out_w - {decay_step[W-1], decay_step};
  assign rel_diff = out_w - {release_step[W-1], release_step};

  // A step of zero or less makes that stage complete in a single tick.
  logic atk_instant, dec_instant, rel_instant;
  assign atk_instant = attack_step[W-1]  || (attack_step  == '0);
  assign dec_instant = decay_step[W-1]   || (decay_step   == '0);
  assign rel_instant = release_step[W-1] || (release_step == '0);

  logic rise;
  assign rise = gate && !prev_gate_q;

  always_comb begin
    state_d     = state_q;
    out_d       = out_q;
    prev_gate_d = prev_gate_q;

    if (sample_tick) prev_gate_d = gate;

    if (!(state_q inside {IDLE, ATTACK, DECAY, SUSTAIN, RELEASE})) begin
      // Corrupted encoding: fall back to a silent envelope at once,
      // whether or not this is a tick cycle.
      state_d = IDLE;
      out_d   = FLOOR;
    end else if (sample_tick) begin
      if (rise) begin
        // Retrigger keeps the current level so there is no click.
        state_d = ATTACK;
      end else if (!gate && (state_q inside {ATTACK, DECAY, SUSTAIN})) begin
        // Entering release keeps the level for this tick.
        state_d = RELEASE;
      end else begin
        unique case (state_q)
          IDLE: begin
            out_d = FLOOR;
          end
          ATTACK: begin
            if (atk_instant || !atk_sum[W]) begin
              out_d   = PEAK;
              state_d = DECAY;
            end else begin
              out_d = atk_sum[W-1:0];
            end
          end
          DECAY: begin
            if (dec_instant || (dec_diff <= sus_w)) begin
              out_d   = sus_c;
              state_d = SUSTAIN;
            end else begin
              out_d = dec_diff[W-1:0];
            end
          end
          SUSTAIN: begin
            // Track live changes to the sustain level.
            out_d = sus_c;
          end
          RELEASE: begin
            if (rel_instant || (rel_diff <= floor_w)) begin
              out_d   = FLOOR;
              state_d = IDLE;
            end else begin
              out_d = rel_diff[W-1:0];
            end
          end
          default: begin
            state_d = IDLE;
            out_d   = FLOOR;
          end
        endcase
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      out_q       <= FLOOR;
      prev_gate_q <= 1'b0;
      valid_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      out_q       <= out_d;
      prev_gate_q <= prev_gate_d;
      valid_q     <= sample_tick;
    end
  end

  assign out       = out_q;
  assign out_valid = valid_q;
  assign stage     = state_q;

endmodule

// File: tb/tb_adsr_env.sv
// tb_adsr_env -- directed bench for adsr_env at default Q16.16 parameters.
module tb_adsr_env;

  logic               clk = 1'b0;
  logic               reset_n = 1'b0;
  logic               sample_tick = 1'b0;
  logic               gate = 1'b0;
  logic signed [31:0] attack_step = '0;
  logic signed [31:0] decay_step = '0;
  logic signed [31:0] release_step = '0;
  logic signed [31:0] sustain_level = '0;
  logic signed [31:0] out;
  logic               out_valid;
  logic [2:0]         stage;

  int n_asserts = 0;
  int n_fail    = 0;

  localparam logic [2:0] S_IDLE = 3'd0, S_ATK = 3'd1, S_DEC = 3'd2,
                         S_SUS = 3'd3, S_REL = 3'd4;

  // Q16.16 constants
  localparam logic [31:0] P0    = 32'h0000_0000;  //  0.0
  localparam logic [31:0] M0125 = 32'hFFFF_E000;  // -0.125
  localparam logic [31:0] M025  = 32'hFFFF_C000;  // -0.25
  localparam logic [31:0] M0375 = 32'hFFFF_A000;  // -0.375
  localparam logic [31:0] M05   = 32'hFFFF_8000;  // -0.5
  localparam logic [31:0] M075  = 32'hFFFF_4000;  // -0.75
  localparam logic [31:0] M1    = 32'hFFFF_0000;  // -1.0
  localparam logic [31:0] M01   = 32'hFFFF_E666;  // -0.1 (-6554)

  adsr_env #(.TOTAL_BITS(32), .FRACTIONAL_BITS(16)) dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .sample_tick   (sample_tick),
    .gate          (gate),
    .attack_step   (attack_step),
    .decay_step    (decay_step),
    .release_step  (release_step),
    .sustain_level (sustain_level),
    .out           (out),
    .out_valid     (out_valid),
    .stage         (stage)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_asserts++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  task automatic chk_state(input string tag, input logic [2:0] es, input logic [31:0] eo);
    chk({tag, ".stage"}, {29'd0, stage}, {29'd0, es});
    chk({tag, ".out"}, out, eo);
  endtask

  // One tick cycle; checks are taken at the following falling edge,
  // where out_valid must be high and out/stage show the new values.
  task automatic tick(input string tag, input logic [2:0] es, input logic [31:0] eo);
    @(negedge clk);
    sample_tick = 1'b1;
    @(negedge clk);
    sample_tick = 1'b0;
    chk({tag, ".valid"}, {31'd0, out_valid}, 32'd1);
    chk_state(tag, es, eo);
  endtask

  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++) @(negedge clk);
  endtask

  initial begin
    // Reset state
    idle_cycles(3);
    chk("rst.valid", {31'd0, out_valid}, 32'd0);
    chk_state("rst", S_IDLE, M1);
    @(negedge clk);
    reset_n = 1'b1;
    idle_cycles(2);
    chk_state("post_rst", S_IDLE, M1);

    // Attack / decay / sustain
    attack_step   = 32'h0000_4000;  // 0.25
    decay_step    = 32'h0000_2000;  // 0.125
    sustain_level = 32'hFFFF_8000;  // -0.5
    release_step  = 32'h0000_8000;  // 0.5
    gate = 1'b1;
    tick("rise", S_ATK, M1);
    @(negedge clk);
    chk("valid_drop", {31'd0, out_valid}, 32'd0);
    tick("atk1", S_ATK, M075);
    tick("atk2", S_ATK, M05);
    tick("atk3", S_ATK, M025);
    tick("atk4", S_DEC, P0);
    tick("dec1", S_DEC, M0125);
    tick("dec2", S_DEC, M025);
    tick("dec3", S_DEC, M0375);
    tick("dec4", S_SUS, M05);

    // Gate toggling with no tick changes nothing
    gate = 1'b0;
    idle_cycles(2);
    gate = 1'b1;
    idle_cycles(2);
    chk("hold.valid", {31'd0, out_valid}, 32'd0);
    chk_state("hold", S_SUS, M05);

    // Release 0.5 from -0.5
    gate = 1'b0;
    tick("rel1", S_REL, M05);
    tick("rel2", S_IDLE, M1);
    tick("idle", S_IDLE, M1);

    // Instant attack, then decay toward a clamped positive sustain
    attack_step = '0;
    gate = 1'b1;
    tick("rise2", S_ATK, M1);
    tick("inst_atk", S_DEC, P0);
    sustain_level = 32'h0000_8000;  // +0.5 clamps to 0.0
    tick("sus_clamp_dec", S_SUS, P0);
    tick("sus_clamp", S_SUS, P0);
    sustain_level = 32'hFFFF_8000;
    tick("sus_track", S_SUS, M05);

    // Release to -0.75 then retrigger
    release_step = 32'h0000_4000;  // 0.25
    gate = 1'b0;
    tick("rel_a", S_REL, M05);
    tick("rel_b", S_REL, M075);
    gate = 1'b1;
    attack_step = 32'h0000_4000;
    tick("retrig", S_ATK, M075);
    tick("retrig_atk", S_ATK, M05);

    // Saturating attack: -0.5 + 0.4 = -0.1, then +0.3 clamps to 0.0
    attack_step = 32'h0000_6666;
    tick("atk_m01", S_ATK, M01);
    attack_step = 32'h0000_4CCD;
    tick("atk_sat", S_DEC, P0);

    // Asynchronous reset in DECAY
    tick("dec_pre_rst", S_DEC, M0125);
    @(negedge clk);
    #2 reset_n = 1'b0;
    #1;
    chk("arst.valid", {31'd0, out_valid}, 32'd0);
    chk_state("arst", S_IDLE, M1);
    idle_cycles(2);
    reset_n = 1'b1;
    // gate still high: first tick after reset is a rising edge
    tick("rst_rise", S_ATK, M1);

    // Instant release
    release_step = '0;
    gate = 1'b0;
    tick("rel_enter", S_REL, M1);
    tick("rel_inst", S_IDLE, M1);

    idle_cycles(2);
    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
    $finish;
  end

endmodule
